// File: rtl/vga_term_writer.sv
// rtl/vga_term_writer.sv - byte stream to VGA character generator write initiator
// Terminal control (CR/LF/BS/FF) is resolved here against a shadow cursor.
module vga_term_writer #(
  parameter int         COLS      = 64,
  parameter int         ROWS      = 32,
  parameter logic [7:0] CLR_CHAR  = 8'h20,
  parameter bit         AUTO_MAIN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_ready_o,
  output logic       wb_cyc_o,
  output logic       wb_we_o,
  output logic [2:0] wb_addr_o,
  output logic [7:0] wb_dato,
  output logic       busy_o,
  output logic [6:0] cur_x_o,
  output logic [4:0] cur_y_o
);

  typedef enum logic [4:0] {
    IDLE, INIT_SEL, INIT_X, INIT_Y,
    CHAR, WRAP_X, WRAP_Y, CR, LF,
    BS1, BS2, BS3,
    CLR_Y, CLR_X, CLR_FILL, CLR_HX, CLR_HY
  } state_t;

  state_t     state, state_nx, disp;
  logic [7:0] byte_q, byte_cur;
  logic       init_done, init_done_nx;
  logic [4:0] row_cnt, row_nx;
  logic [6:0] col_cnt, col_nx;
  logic [6:0] cur_x, x_nx;
  logic [4:0] cur_y, y_nx;
  logic       rdy_q, accept;
  logic       cyc_q, cyc_nx;
  logic [2:0] addr_q, addr_nx;
  logic [7:0] dat_q, dat_nx;

  assign accept   = rx_valid_i && rdy_q;
  // After init the latched byte is dispatched; otherwise the byte is decoded as it arrives.
  assign byte_cur = (state == INIT_Y) ? byte_q : rx_data_i;

  always_comb begin
    disp = IDLE;
    if (byte_cur >= 8'h20 && byte_cur <= 8'h7E) begin
      disp = CHAR;
    end else begin
      case (byte_cur)
        8'h0D:   disp = CR;
        8'h0A:   disp = LF;
        8'h08:   if (cur_x != 7'd0) disp = BS1;
        8'h0C:   disp = CLR_Y;
        default: disp = IDLE;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    row_nx       = row_cnt;
    init_done_nx = init_done;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!init_done) state_nx = AUTO_MAIN ? INIT_SEL : INIT_X;
          else            state_nx = disp;
        end
      end
      INIT_SEL: state_nx = INIT_X;
      INIT_X:   state_nx = INIT_Y;
      INIT_Y: begin
        state_nx     = disp;
        init_done_nx = 1'b1;
      end
      CHAR:     state_nx = (cur_x == 7'(COLS)) ? WRAP_X : IDLE;
      WRAP_X:   state_nx = WRAP_Y;
      BS1:      state_nx = BS2;
      BS2:      state_nx = BS3;
      CLR_Y:    state_nx = CLR_X;
      CLR_X:    state_nx = CLR_FILL;
      CLR_FILL: begin
        if (col_cnt == 7'(COLS)) begin
          if (row_cnt == 5'(ROWS - 1)) begin
            state_nx = CLR_HX;
          end else begin
            state_nx = CLR_Y;
            row_nx   = row_cnt + 5'd1;
          end
        end
      end
      CLR_HX:   state_nx = CLR_HY;
      default:  state_nx = IDLE;
    endcase
    if (state_nx == CLR_Y && state != CLR_FILL) row_nx = 5'd0;
  end

  // Each state entered performs exactly one bus write; the cursor moves with the write that implies it.
  always_comb begin
    cyc_nx  = 1'b1;
    addr_nx = 3'd0;
    dat_nx  = 8'h00;
    x_nx    = cur_x;
    y_nx    = cur_y;
    col_nx  = col_cnt;
    case (state_nx)
      INIT_SEL: addr_nx = 3'd6;
      INIT_X:   addr_nx = 3'd1;
      INIT_Y:   addr_nx = 3'd3;
      CHAR: begin
        dat_nx = byte_cur;
        x_nx   = cur_x + 7'd1;
      end
      WRAP_X, CR, CLR_HX: begin
        addr_nx = 3'd1;
        x_nx    = 7'd0;
      end
      WRAP_Y, LF: begin
        addr_nx = 3'd3;
        dat_nx  = {3'b000, cur_y + 5'd1};
        y_nx    = cur_y + 5'd1;
      end
      BS1: begin
        addr_nx = 3'd1;
        dat_nx  = {1'b0, cur_x - 7'd1};
      end
      BS2:      dat_nx = CLR_CHAR;
      BS3: begin
        addr_nx = 3'd1;
        dat_nx  = {1'b0, cur_x - 7'd1};
        x_nx    = cur_x - 7'd1;
      end
      CLR_Y: begin
        addr_nx = 3'd3;
        dat_nx  = {3'b000, row_nx};
      end
      CLR_X: begin
        addr_nx = 3'd1;
        col_nx  = 7'd0;
      end
      CLR_FILL: begin
        dat_nx = CLR_CHAR;
        col_nx = col_cnt + 7'd1;
      end
      CLR_HY: begin
        addr_nx = 3'd3;
        y_nx    = 5'd0;
      end
      default:  cyc_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      byte_q    <= 8'h00;
      init_done <= 1'b0;
      row_cnt   <= 5'd0;
      col_cnt   <= 7'd0;
      cur_x     <= 7'd0;
      cur_y     <= 5'd0;
      rdy_q     <= 1'b0;
      cyc_q     <= 1'b0;
      addr_q    <= 3'd0;
      dat_q     <= 8'h00;
    end else begin
      state     <= state_nx;
      if (accept) byte_q <= rx_data_i;
      init_done <= init_done_nx;
      row_cnt   <= row_nx;
      col_cnt   <= col_nx;
      cur_x     <= x_nx;
      cur_y     <= y_nx;
      rdy_q     <= (state_nx == IDLE) && !accept;
      cyc_q     <= cyc_nx;
      addr_q    <= addr_nx;
      dat_q     <= dat_nx;
    end
  end

  assign rx_ready_o = rdy_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_we_o    = cyc_q;
  assign wb_addr_o  = addr_q;
  assign wb_dato    = dat_q;
  assign busy_o     = (state != IDLE);
  assign cur_x_o    = cur_x;
  assign cur_y_o    = cur_y;

endmodule

// File: tb/tb_vga_term_writer.sv
// tb/tb_vga_term_writer.sv - directed vector bench for vga_term_writer
module tb_vga_term_writer;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       rx_ready_o;
  logic       wb_cyc_o;
  logic       wb_we_o;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_dato;
  logic       busy_o;
  logic [6:0] cur_x_o;
  logic [4:0] cur_y_o;

  vga_term_writer dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_o (rx_ready_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_we_o    (wb_we_o),
    .wb_addr_o  (wb_addr_o),
    .wb_dato    (wb_dato),
    .busy_o     (busy_o),
    .cur_x_o    (cur_x_o),
    .cur_y_o    (cur_y_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [10:0] w;
    int          c;
  } wr_t;

  // Expected writes are {addr[2:0], data[7:0]}, so 11'h104 reads as addr 1, data 04.
  typedef struct {
    logic [7:0]       b;
    int               nw;
    logic [3:0][10:0] w;
    int               ex;
    int               ey;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   bad_we = 0;
  wr_t  wq[$];
  vec_t tbl[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (wb_we_o !== wb_cyc_o) bad_we++;
    if (wb_cyc_o === 1'b1) wq.push_back('{w: {wb_addr_o, wb_dato}, c: cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic vec_t mk(logic [7:0] b, int nw, logic [10:0] w0, logic [10:0] w1,
                              logic [10:0] w2, logic [10:0] w3, int ex, int ey);
    vec_t v;
    v.b = b; v.nw = nw; v.ex = ex; v.ey = ey;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  task automatic send_collect(input logic [7:0] b, output int acc, output int rdy, output bit hs);
    int n;
    hs = 1'b0;
    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    n = 0;
    while (!rx_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) timeout("accept_wait");
    acc = cyc;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    if (rx_ready_o) hs = 1'b1;
    n = 0;
    while (!rx_ready_o && n < 5000) begin
      if (wb_cyc_o && !busy_o) hs = 1'b1;
      @(negedge clk_i);
      n++;
    end
    if (n >= 5000) timeout("ready_wait");
    rdy = cyc;
  endtask

  task automatic run_vec(input vec_t v);
    int acc, rdy;
    bit hs;
    wq.delete();
    send_collect(v.b, acc, rdy, hs);
    chk($sformatf("b%02h_nwrites", v.b), wq.size(), v.nw);
    for (int i = 0; i < v.nw && i < wq.size(); i++) begin
      chk($sformatf("b%02h_wr%0d", v.b, i), wq[i].w, v.w[i]);
      chk($sformatf("b%02h_wr%0d_cycle", v.b, i), wq[i].c, acc + 1 + i);
    end
    chk($sformatf("b%02h_ready_cycle", v.b), rdy, acc + 1 + ((v.nw > 0) ? v.nw : 1));
    chk($sformatf("b%02h_handshake", v.b), hs, 1'b0);
    chk($sformatf("b%02h_cur_x", v.b), cur_x_o, v.ex);
    chk($sformatf("b%02h_cur_y", v.b), cur_y_o, v.ey);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rdy, bad, fills;
    bit hs;
    logic [10:0] e;

    tbl.push_back(mk(8'h41, 4, 11'h600, 11'h100, 11'h300, 11'h041, 1, 0));
    tbl.push_back(mk(8'h44, 1, 11'h044, 0, 0, 0, 2, 0));
    tbl.push_back(mk(8'h45, 1, 11'h045, 0, 0, 0, 3, 0));
    tbl.push_back(mk(8'h46, 1, 11'h046, 0, 0, 0, 4, 0));
    tbl.push_back(mk(8'h47, 1, 11'h047, 0, 0, 0, 5, 0));
    tbl.push_back(mk(8'h08, 3, 11'h104, 11'h020, 11'h104, 0, 4, 0));
    tbl.push_back(mk(8'h0D, 1, 11'h100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h08, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h07, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h7F, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hC3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h0A, 1, 11'h301, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h7E, 1, 11'h07E, 0, 0, 0, 1, 1));
    tbl.push_back(mk(8'h20, 1, 11'h020, 0, 0, 0, 2, 1));

    rst_n_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {rx_ready_o, wb_cyc_o, wb_we_o, wb_addr_o, wb_dato, busy_o, cur_x_o, cur_y_o}, 0);
    rst_n_i = 1'b1;
    chk("ready_before_first_edge", rx_ready_o, 1'b0);
    @(negedge clk_i);
    chk("ready_after_release", rx_ready_o, 1'b1);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    for (int y = 2; y < 32; y++) run_vec(mk(8'h0A, 1, {3'd3, 3'd0, 5'(y)}, 0, 0, 0, 2, y));
    run_vec(mk(8'h0A, 1, 11'h300, 0, 0, 0, 2, 0));

    for (int i = 0; i < 8; i++) run_vec(mk(8'h61 + 8'(i), 1, {3'd0, 8'h61 + 8'(i)}, 0, 0, 0, 3 + i, 0));
    run_vec(mk(8'h0D, 1, 11'h100, 0, 0, 0, 0, 0));

    for (int i = 0; i < 63; i++) run_vec(mk(8'h42, 1, 11'h042, 0, 0, 0, i + 1, 0));
    run_vec(mk(8'h42, 3, 11'h042, 11'h100, 11'h301, 0, 0, 1));
    run_vec(mk(8'h43, 1, 11'h043, 0, 0, 0, 1, 1));

    wq.delete();
    send_collect(8'h0C, acc, rdy, hs);
    chk("clr_count", wq.size(), 2114);
    bad   = 0;
    fills = 0;
    for (int i = 0; i < wq.size(); i++) begin
      if (i < 2112) begin
        if (i % 66 == 0)      e = {3'd3, 3'd0, 5'(i / 66)};
        else if (i % 66 == 1) e = 11'h100;
        else                  e = 11'h020;
      end else begin
        e = (i == 2112) ? 11'h100 : 11'h300;
      end
      if (wq[i].w !== e || wq[i].c != acc + 1 + i) bad++;
      if (wq[i].w === 11'h020) fills++;
    end
    chk("clr_sequence_errors", bad, 0);
    chk("clr_fill_count", fills, 2048);
    chk("clr_ready_cycle", rdy, acc + 2115);
    chk("clr_handshake", hs, 1'b0);
    chk("clr_cur", {cur_x_o, cur_y_o}, 0);

    run_vec(mk(8'h4A, 1, 11'h04A, 0, 0, 0, 1, 0));

    @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h0C;
    chk("midclr_ready", rx_ready_o, 1'b1);
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    repeat (100) @(negedge clk_i);
    @(posedge clk_i);
    #2;
    chk("midclr_cyc_before", wb_cyc_o, 1'b1);
    rst_n_i = 1'b0;
    #1;
    chk("midclr_cyc_async_low", wb_cyc_o, 1'b0);
    chk("midclr_busy_async_low", busy_o, 1'b0);
    chk("midclr_cur_reset", {cur_x_o, cur_y_o}, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("midclr_ready_after_release", rx_ready_o, 1'b1);
    run_vec(mk(8'h41, 4, 11'h600, 11'h100, 11'h300, 11'h041, 1, 0));

    chk("we_tracks_cyc", bad_we, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
